sub_bytes_engine: RTL and testbench
===================================

Name: sub_bytes_engine

Overview:
Iterative, parametrised AES SubBytes / InvSubBytes engine for a full 128-bit state.
- Direction is selectable per transaction.
- LANES S-box lanes are time-multiplexed over the 16 state bytes.
- Valid/ready handshakes on input and output.
- Sits between the AddRoundKey and ShiftRows stages of the shared encrypt/decrypt datapath, and lets area be traded against latency.

Parameters:
- LANES, 4, S-box lanes instantiated. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration-time error.
- N_STEPS, 16/LANES, derived localparam: processing cycles per block.
- CNT_W, max(1, clog2(N_STEPS)), derived localparam: width of the step counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data/in_inv are valid
- in_ready  output  1  engine can accept a block this cycle
- in_data  input  128  state; byte k = in_data[8k+7:8k]
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box
- out_valid  output  1  out_data holds a completed block
- out_ready  input  1  downstream accepts out_data
- out_data  output  128  substituted state, same byte mapping as in_data

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, counter = 0, working register = 0, mode register = 0.
  - in_ready = 1, out_valid = 0, out_data = 0.
- States:
  - IDLE: in_ready = 1. If in_valid, latch in_data to the working register, latch in_inv to the mode register, clear the counter, go to BUSY.
  - BUSY: in_ready = 0, out_valid = 0.
    - Each cycle, bytes [counter*LANES .. counter*LANES+LANES-1] of the working register are replaced by S(byte) or S^-1(byte), per the mode register.
    - The counter increments each cycle.
    - When the counter = N_STEPS-1, that cycle's update completes and the next state is DONE.
  - DONE: out_valid = 1, out_data = working register, held stable until out_ready.
    - in_ready = out_ready.
    - out_ready=1 and in_valid=1: accept the new block in the same cycle, go to BUSY (back-to-back).
    - out_ready=1 and in_valid=0: go to IDLE; out_data keeps its last value but out_valid = 0.
- Latency:
  - out_valid rises exactly N_STEPS cycles after the accepting edge.
  - Throughput is one block per N_STEPS+1 cycles. LANES=16 gives latency 1, throughput 1 per 2.
- Mode is sampled only at accept; in_inv changes during BUSY have no effect.
- in_valid during BUSY is not accepted (in_ready=0). The upstream must hold its data.
- out_ready while not in DONE is ignored.
- Reset asserted mid-BUSY or mid-DONE aborts the block. There is no partial output, and out_valid drops asynchronously.
- Bytes not yet processed remain the raw input bytes; they are never visible because out_valid=0 during BUSY.
- The S-box function is the exact AES table (FIPS-197). The inverse must satisfy S^-1(S(x)) = x for all 256 x.
- No combinational path from in_* to out_*. in_ready depends combinationally only on state and out_ready.

Decomposition:
- Package aes_sbox_pkg:
  - 256-entry forward and inverse S-box constant tables.
  - Functions sbox_fwd(byte) and sbox_inv(byte).
  - FSM state enum {IDLE, BUSY, DONE}.
- Sub-module sbox_lane (combinational): inputs byte_in[7:0] and inv; output byte_out[7:0]; implemented from the package tables. The engine instantiates LANES copies.
- Lane-to-byte routing: an indexed part-select by counter in the engine. There is no separate mux module.

Test Plan:
1. FIPS-197 vector, LANES=4, in_inv=0:
   - Stimulus: in_data=128'h193de3bea0f4e22b9ac68d2ae9f84808.
   - Required: out_data=128'hd42711aee0bf98f1b8b45de51e415230, with out_valid exactly 4 cycles after accept.
2. Inverse:
   - Stimulus: 128'hd42711aee0bf98f1b8b45de51e415230 with in_inv=1.
   - Required: 128'h193de3bea0f4e22b9ac68d2ae9f84808.
   - Also: all-0x63 input returns all-0x00.
3. Exhaustive round-trip for LANES ∈ {1,2,4,8,16}:
   - Stimulus: 16 blocks covering bytes 0x00..0xFF, forward then inverse.
   - Required: each block returns its original value; latency is 16, 8, 4, 2, 1 respectively.
4. Backpressure, LANES=4:
   - Stimulus: hold out_ready=0 for 10 cycles after out_valid.
   - Required: out_data stable, in_ready=0, and a second block offered meanwhile is not taken.
   - Then out_ready=1 with in_valid=1: the new block is accepted in the same cycle; next out_valid comes 4 cycles later.
5. Mode sampling:
   - Stimulus: toggle in_inv every cycle during BUSY.
   - Required: the result matches the mode present at the accept edge.
6. Reset mid-operation:
   - Stimulus: assert rst on the 2nd BUSY cycle.
   - Required: out_valid=0, out_data=0, in_ready=1 immediately; the next block completes normally with correct data.

Source files
------------

// File: rtl/aes_sbox_pkg.sv
// Shared AES S-box tables, lookup helpers and the engine FSM state type.
package aes_sbox_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // Entry b sits at index b; each 128-bit literal holds one table row of 16 bytes.
  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD[b];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV[b];
  endfunction

  // Lane counts must divide the 16 state bytes into a power-of-two number of steps.
  function automatic bit lanes_legal(input int unsigned lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane; direction chosen by inv.
module sbox_lane
  import aes_sbox_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic       inv,
  output logic [7:0] byte_out
);

  // Table lookup in the requested direction.
  always_comb begin
    byte_out = inv ? sbox_inv(byte_in) : sbox_fwd(byte_in);
  end

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative SubBytes / InvSubBytes over a 128-bit state, LANES bytes per cycle.
module sub_bytes_engine
  import aes_sbox_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int unsigned N_STEPS = 16 / LANES;
  localparam int unsigned CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  if (!lanes_legal(LANES)) begin : gen_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0][7:0]    work_q, work_d;
  logic                inv_q, inv_d;

  logic [3:0]             byte_base;
  logic [LANES-1:0][3:0]  lane_pos;
  logic [LANES-1:0][7:0]  lane_out;

  // First byte handled this step; wraps harmlessly to 0 when LANES = 16 (counter stays 0).
  assign byte_base = 4'(cnt_q) * 4'(LANES);

  for (genvar i = 0; i < LANES; i++) begin : gen_lane
    assign lane_pos[i] = byte_base + 4'(i);
    sbox_lane u_lane (
      .byte_in  (work_q[lane_pos[i]]),
      .inv      (inv_q),
      .byte_out (lane_out[i])
    );
  end

  assign out_data = work_q;

  // Next-state, handshake outputs and in-place byte substitution.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    inv_d     = inv_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_data;
          inv_d   = in_inv;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          work_d[lane_pos[i]] = lane_out[i];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_STEPS - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        // Ready to take a new block only when the finished one leaves this cycle.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d  = in_data;
            inv_d   = in_inv;
            cnt_d   = '0;
            state_d = StBusy;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      work_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      inv_q   <= inv_d;
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Scoreboard bench: LANES=4 instance for directed scenarios, plus one instance
// per legal LANES value running an exhaustive forward/inverse round trip.
module tb_sub_bytes_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rst_sw = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_inv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit sweep_go = 1'b0;

  logic [7:0]   m_fwd [256];
  logic [7:0]   m_inv [256];
  logic [127:0] sb [$];
  logic [127:0] drv_exp = '0;
  bit           pend = 1'b0;
  int           acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_bytes_engine #(.LANES(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box built from its algebraic definition: field inverse then affine map.
  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] a = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) a = 8'(y);
      end
      s = a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
      m_fwd[x] = s;
      m_inv[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_blk(input logic [127:0] d, input bit inv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv ? m_inv[d[8*k +: 8]] : m_fwd[d[8*k +: 8]];
    return r;
  endfunction

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      pend = 1'b0;
    end else begin
      if (pend && out_valid) begin
        check("latency", 128'(cyc - acc_cyc), 128'd4);
        pend = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("spurious_out", out_data, 128'hx);
        else check("out_data", out_data, sb.pop_front());
      end
      if (in_valid && in_ready) begin
        sb.push_back(drv_exp);
        pend = 1'b1;
        acc_cyc = cyc + 1;
      end
    end
  end

  // Offer a block and return #1 after the accepting edge.
  task automatic send(input logic [127:0] d, input bit inv, input logic [127:0] exp);
    int n = 0;
    in_data = d;
    in_inv = inv;
    drv_exp = exp;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 128'(sb.size()), 128'd0);
  endtask

  for (genvar gi = 0; gi < 5; gi++) begin : g_sweep
    localparam int L = 1 << gi;
    logic         s_in_valid = 1'b0;
    logic         s_in_ready;
    logic         s_in_inv = 1'b0;
    logic [127:0] s_in_data = '0;
    logic         s_out_valid;
    logic [127:0] s_out_data;
    bit           done_flag = 1'b0;

    sub_bytes_engine #(.LANES(L)) u_dut (
      .clk       (clk),
      .rst       (rst_sw),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in_data),
      .in_inv    (s_in_inv),
      .out_valid (s_out_valid),
      .out_ready (1'b1),
      .out_data  (s_out_data)
    );

    initial begin
      logic [127:0] orig, cur, res;
      int lat;
      wait (sweep_go);
      @(posedge clk);
      #1;
      for (int blk = 0; blk < 16; blk++) begin
        for (int k = 0; k < 16; k++) orig[8*k +: 8] = 8'(blk * 16 + k);
        cur = orig;
        for (int dir = 0; dir < 2; dir++) begin
          s_in_data = cur;
          s_in_inv = dir[0];
          s_in_valid = 1'b1;
          check($sformatf("sw%0d_ready", L), 128'(s_in_ready), 128'd1);
          @(posedge clk);
          #1;
          s_in_valid = 1'b0;
          lat = 0;
          while (!s_out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
          end
          check($sformatf("sw%0d_lat", L), 128'(lat), 128'(16 / L));
          res = s_out_data;
          check($sformatf("sw%0d_dir%0d_blk%0d", L, dir, blk), res, model_blk(cur, dir[0]));
          cur = res;
        end
        check($sformatf("sw%0d_round_blk%0d", L, blk), cur, orig);
      end
      done_flag = 1'b1;
    end
  end

  initial begin
    logic [127:0] d, d2, e1;
    int n;
    build_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    rst = 1'b0;
    rst_sw = 1'b0;
    sweep_go = 1'b1;

    // FIPS-197 vectors and the all-0x63 inverse.
    send(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230);
    drain();
    send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    drain();
    send({16{8'h63}}, 1'b1, 128'd0);
    drain();

    // A few random blocks in both directions, some back to back.
    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, i[0], model_blk(d, i[0]));
    end
    drain();

    // Mode is taken at accept only.
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 1'b0, model_blk(d, 1'b0));
    for (int i = 0; i < 5; i++) begin
      in_inv = ~in_inv;
      @(posedge clk);
      #1;
    end
    drain();
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 1'b1, model_blk(d, 1'b1));
    for (int i = 0; i < 5; i++) begin
      in_inv = ~in_inv;
      @(posedge clk);
      #1;
    end
    drain();

    // Backpressure: hold the result, refuse a second block, then accept it back to back.
    out_ready = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    e1 = model_blk(d, 1'b0);
    send(d, 1'b0, e1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", 128'(out_valid), 128'd1);
    d2 = {$urandom, $urandom, $urandom, $urandom};
    in_data = d2;
    in_inv = 1'b1;
    drv_exp = model_blk(d2, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_data_stable", out_data, e1);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      check("bp_out_valid", 128'(out_valid), 128'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_b2b_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Reset on the second busy cycle aborts the block.
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 1'b0, model_blk(d, 1'b0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_out_data", out_data, 128'd0);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 1'b1, model_blk(d, 1'b1));
    drain();

    n = 0;
    while (!(g_sweep[0].done_flag && g_sweep[1].done_flag && g_sweep[2].done_flag &&
             g_sweep[3].done_flag && g_sweep[4].done_flag) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("sweeps_done", 128'(n < 5000), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
